// File: rtl/test_rom_loader.sv
// Copies the two populated test-ROM regions (program, then cartridge header) into SDRAM
// through a req/ack write port, one byte per ROM read.
module test_rom_loader #(
  parameter logic [21:0] ROM_END   = 22'h0004E4,
  parameter logic [21:0] HDR_START = 22'h007FC0,
  parameter logic [21:0] HDR_END   = 22'h008000,
  parameter logic [21:0] LOAD_BASE = 22'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [21:0] rom_addr,
  input  logic [7:0]  rom_dout,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0] state;

  // SDRAM placement wraps naturally at the 22-bit address width.
  function automatic logic [21:0] map_addr(input logic [21:0] a);
    return a + LOAD_BASE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      mem_addr   <= LOAD_BASE;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rom_addr   <= '0;
            byte_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: state <= LATCH;
        LATCH: begin
          mem_din  <= rom_dout;
          mem_addr <= map_addr(rom_addr);
          mem_we   <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we     <= 1'b0;
            byte_count <= byte_count + 16'd1;
            // Skip the unpopulated gap between program and header.
            if (rom_addr == ROM_END - 22'd1) begin
              rom_addr <= HDR_START;
              state    <= ADDR;
            end else if (rom_addr == HDR_END - 22'd1) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 22'd1;
              state    <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_rom_loader.sv
// Scoreboard bench for test_rom_loader: expected SDRAM writes are queued at start,
// monitors compare every presented write against the queue head.
module tb_test_rom_loader;

  localparam int ROM_END_I   = 'h4E4;
  localparam int HDR_START_I = 'h7FC0;
  localparam int HDR_END_I   = 'h8000;
  localparam logic [21:0] BASE1 = 22'h3FFFF0;

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start1, mem_ack, mem_ack1;
  logic [21:0] rom_addr, mem_addr, rom_addr_1, mem_addr_1;
  logic [7:0]  rom_dout, mem_din, rom_dout_1, mem_din_1;
  logic        mem_we, busy, done, mem_we_1, busy_1, done_1;
  logic [15:0] byte_count, byte_count_1;

  test_rom_loader dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  test_rom_loader #(.LOAD_BASE(BASE1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rom_addr(rom_addr_1), .rom_dout(rom_dout_1),
    .mem_addr(mem_addr_1), .mem_din(mem_din_1), .mem_we(mem_we_1), .mem_ack(mem_ack1),
    .busy(busy_1), .done(done_1), .byte_count(byte_count_1)
  );

  function automatic logic [7:0] romval(input int a);
    return 8'(a ^ (a >> 7) ^ 32'h5A);
  endfunction

  logic [7:0] rom [0:32767];
  initial for (int i = 0; i < 32768; i++) rom[i] = romval(i);

  always_ff @(posedge clk) begin
    rom_dout   <= rom[rom_addr[14:0]];
    rom_dout_1 <= rom[rom_addr_1[14:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  wr_t q0[$];
  wr_t q1[$];
  bit  mon0 = 1'b0, mon1 = 1'b0, chkd0 = 1'b0, chkd1 = 1'b0;
  int  pop0 = 0, pop1 = 0;
  logic [21:0] last0 = '0;

  task automatic push_all(input logic [21:0] base, input bit which);
    wr_t w;
    for (int a = 0; a < ROM_END_I; a++) begin
      w.a = 22'(a) + base;
      w.d = romval(a);
      if (which) q1.push_back(w); else q0.push_back(w);
    end
    for (int a = HDR_START_I; a < HDR_END_I; a++) begin
      w.a = 22'(a) + base;
      w.d = romval(a);
      if (which) q1.push_back(w); else q0.push_back(w);
    end
  endtask

  // mem_ack driver: mode 0 = never ack, 1 = always high, 2 = stall byte 3 for five cycles
  int mode = 1;
  int hold3 = 0;
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_we && mode == 2 && mem_addr == 22'd3) begin
        hold3++;
        mem_ack = (hold3 >= 5);
      end else begin
        mem_ack = (mode != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon0 && mem_we) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write0: got write at 0x%0h, required none", mem_addr);
        end else begin
          check("wr_addr0", 32'(mem_addr), 32'(q0[0].a));
          check("wr_data0", 32'(mem_din), 32'(q0[0].d));
          if (mem_ack) begin
            check("count0", 32'(byte_count), 32'(pop0));
            last0 = mem_addr;
            void'(q0.pop_front());
            pop0++;
          end
        end
      end
      if (chkd0 && q0.size() != 0) check("early_done0", 32'(done), 32'd0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon1 && mem_we_1) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write1: got write at 0x%0h, required none", mem_addr_1);
        end else begin
          check("wr_addr1", 32'(mem_addr_1), 32'(q1[0].a));
          check("wr_data1", 32'(mem_din_1), 32'(q1[0].d));
          if (mem_ack1) begin
            if (pop1 == 16) check("wrap_addr1", 32'(mem_addr_1), 32'h0);
            if (pop1 == 1252) check("hdr_addr1", 32'(mem_addr_1), 32'h007FB0);
            void'(q1.pop_front());
            pop1++;
          end
        end
      end
      if (chkd1 && q1.size() != 0) check("early_done1", 32'(done_1), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int cyc;

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; mem_ack1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_din", 32'(mem_din), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_count", 32'(byte_count), 32'h0);
    check("rst_mem_addr1", 32'(mem_addr_1), 32'(BASE1));
    @(negedge clk) reset = 1'b0;

    // mem_ack high while idle must not start anything
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_we", 32'(mem_we), 32'h0);
    check("idle_count", 32'(byte_count), 32'h0);

    // Full load, ack tied high, plus ignored starts while busy
    push_all(22'h0, 1'b0);
    push_all(BASE1, 1'b1);
    pop0 = 0; pop1 = 0; mon0 = 1'b1; mon1 = 1'b1;
    @(negedge clk);
    start = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start1 = 1'b0;
    chkd0 = 1'b1; chkd1 = 1'b1;
    check("run1_busy", 32'(busy), 32'h1);
    cyc = 0;
    while (!(done && done_1) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == 10 || cyc == 100);
    end
    start = 1'b0;
    check("run1_cycles", 32'(cyc), 32'd3948);
    check("run1_done", 32'(done), 32'h1);
    check("run1_busy_end", 32'(busy), 32'h0);
    check("run1_count", 32'(byte_count), 32'h524);
    check("run1_pending", 32'(q0.size()), 32'd0);
    check("run1_last_addr", 32'(last0), 32'h7FFF);
    check("run1_done1", 32'(done_1), 32'h1);
    check("run1_count1", 32'(byte_count_1), 32'h524);
    check("run1_pending1", 32'(q1.size()), 32'd0);
    chkd0 = 1'b0; chkd1 = 1'b0;

    // Restart from DONE with byte 3 acknowledged late
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", 32'(done), 32'h1);
    mode = 2; hold3 = 0;
    push_all(22'h0, 1'b0);
    pop0 = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chkd0 = 1'b1;
    check("restart_done", 32'(done), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_count", 32'(byte_count), 32'h0);
    check("restart_rom_addr", 32'(rom_addr), 32'h0);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("run2_cycles", 32'(cyc), 32'd3952);
    check("run2_hold3", 32'(hold3), 32'd5);
    check("run2_count", 32'(byte_count), 32'h524);
    check("run2_pending", 32'(q0.size()), 32'd0);
    chkd0 = 1'b0;

    // Async reset in the middle of an unacknowledged write
    mode = 0; mon0 = 1'b0; mon1 = 1'b0;
    q0.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!mem_we && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ar_we_before", 32'(mem_we), 32'h1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ar_we", 32'(mem_we), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    check("ar_rom_addr", 32'(rom_addr), 32'h0);
    check("ar_mem_addr", 32'(mem_addr), 32'h0);
    check("ar_mem_din", 32'(mem_din), 32'h0);
    check("ar_count", 32'(byte_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mode = 1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_we", 32'(mem_we), 32'h0);
    check("post_rst_count", 32'(byte_count), 32'h0);
    check("post_rst_rom_addr", 32'(rom_addr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
